// File: rtl/biquad_coef_loader.sv
// biquad_coef_loader
// Writer end of the biquad parameter port. Receives coefficient frames as a
// byte stream from the control path and assembles them in shadow registers.
// Each frame is: sync byte, n_coefs * (data_width/8) data bytes (MSB first),
// then one XOR checksum byte over the data bytes. A good frame is committed
// atomically to the biquad between samples; hold stays high for the whole
// commit.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   in_data/in_valid  control-path byte stream
//   in_ready          byte accepted on a cycle with in_valid && in_ready
//   biq_ready         biquad idle between samples
//   biq_start         start strobe being issued to the biquad this cycle
//   param_in          coefficient value to the biquad
//   param_target      coefficient index (0..n_coefs-1: b0,b1,b2,a1,a2)
//   write_param       coefficient write strobe
//   hold              high while a commit is in progress
//   load_done         one-cycle pulse after the last coefficient is written
//   csum_err          one-cycle pulse when a frame is rejected
// All outputs are registered.
module biquad_coef_loader #(
  parameter int         data_width = 16,
  parameter int         n_coefs    = 5,
  parameter logic [7:0] sync_byte  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  biq_ready,
  input  logic                  biq_start,
  output logic [data_width-1:0] param_in,
  output logic [2:0]            param_target,
  output logic                  write_param,
  output logic                  hold,
  output logic                  load_done,
  output logic                  csum_err
);

  localparam int bpc = data_width / 8;
  localparam int bw  = (bpc > 1) ? $clog2(bpc) : 1;
  // Index counters are 3 bits wide to match param_target (n_coefs <= 7).
  localparam logic [2:0]    last_coef_c = 3'(n_coefs - 1);
  localparam logic [2:0]    n_coefs_c   = 3'(n_coefs);
  localparam logic [bw-1:0] last_byte_c = bw'(bpc - 1);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    DATA    = 3'd1,
    CSUM    = 3'd2,
    PENDING = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [data_width-1:0] shadow_r [n_coefs];
  logic [data_width-1:0] shadow_s [n_coefs];
  logic [7:0]            xor_r, xor_s;
  logic [bw-1:0]         byte_idx_r, byte_idx_s;
  logic [2:0]            coef_idx_r, coef_idx_s;
  logic [2:0]            commit_idx_r, commit_idx_s;

  logic                  in_ready_r, in_ready_s;
  logic [data_width-1:0] param_in_r, param_in_s;
  logic [2:0]            param_target_r, param_target_s;
  logic                  write_param_r, write_param_s;
  logic                  hold_r, hold_s;
  logic                  load_done_r, load_done_s;
  logic                  csum_err_r, csum_err_s;
  logic                  accept_s;

  // Running checksum step over data bytes.
  function automatic logic [7:0] csum_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Next-state and next-output logic; pulses default low, the rest hold.
  always_comb begin
    state_s        = state_r;
    shadow_s       = shadow_r;
    xor_s          = xor_r;
    byte_idx_s     = byte_idx_r;
    coef_idx_s     = coef_idx_r;
    commit_idx_s   = commit_idx_r;
    in_ready_s     = in_ready_r;
    param_in_s     = param_in_r;
    param_target_s = param_target_r;
    write_param_s  = 1'b0;
    hold_s         = hold_r;
    load_done_s    = 1'b0;
    csum_err_s     = 1'b0;
    accept_s       = in_valid && in_ready_r;

    case (state_r)
      HUNT: begin
        in_ready_s = 1'b1;
        if (accept_s && (in_data == sync_byte)) begin
          xor_s      = 8'h00;
          byte_idx_s = '0;
          coef_idx_s = 3'd0;
          state_s    = DATA;
        end else begin
          state_s = HUNT;
        end
      end

      DATA: begin
        in_ready_s = 1'b1;
        if (accept_s) begin
          // A sync byte value here is ordinary data.
          shadow_s[coef_idx_r] = (shadow_r[coef_idx_r] << 8) | data_width'(in_data);
          xor_s = csum_acc(xor_r, in_data);
          if ((coef_idx_r == last_coef_c) && (byte_idx_r == last_byte_c)) begin
            state_s = CSUM;
          end else if (byte_idx_r == last_byte_c) begin
            byte_idx_s = '0;
            coef_idx_s = coef_idx_r + 3'd1;
          end else begin
            byte_idx_s = byte_idx_r + bw'(1);
          end
        end else begin
          state_s = DATA;
        end
      end

      CSUM: begin
        in_ready_s = 1'b1;
        if (accept_s) begin
          if (in_data == xor_r) begin
            in_ready_s = 1'b0;
            state_s    = PENDING;
          end else begin
            // Rejected frame: live coefficients in the biquad are untouched.
            csum_err_s = 1'b1;
            shadow_s   = '{default: '0};
            state_s    = HUNT;
          end
        end else begin
          state_s = CSUM;
        end
      end

      PENDING: begin
        // No double buffering, so the byte stream is stalled until commit ends.
        in_ready_s = 1'b0;
        if (biq_ready && !biq_start) begin
          write_param_s  = 1'b1;
          param_target_s = 3'd0;
          param_in_s     = shadow_r[0];
          hold_s         = 1'b1;
          commit_idx_s   = 3'd1;
          state_s        = COMMIT;
        end else begin
          state_s = PENDING;
        end
      end

      COMMIT: begin
        // biq_ready / biq_start are deliberately ignored: hold owns the biquad.
        in_ready_s = 1'b0;
        if (commit_idx_r < n_coefs_c) begin
          write_param_s  = 1'b1;
          param_target_s = commit_idx_r;
          param_in_s     = shadow_r[commit_idx_r];
          commit_idx_s   = commit_idx_r + 3'd1;
        end else begin
          hold_s      = 1'b0;
          load_done_s = 1'b1;
          in_ready_s  = 1'b1;
          state_s     = HUNT;
        end
      end

      default: begin
        in_ready_s = 1'b0;
        hold_s     = 1'b0;
        state_s    = HUNT;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= HUNT;
      shadow_r       <= '{default: '0};
      xor_r          <= 8'h00;
      byte_idx_r     <= '0;
      coef_idx_r     <= 3'd0;
      commit_idx_r   <= 3'd0;
      in_ready_r     <= 1'b0;
      param_in_r     <= '0;
      param_target_r <= 3'd0;
      write_param_r  <= 1'b0;
      hold_r         <= 1'b0;
      load_done_r    <= 1'b0;
      csum_err_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      shadow_r       <= shadow_s;
      xor_r          <= xor_s;
      byte_idx_r     <= byte_idx_s;
      coef_idx_r     <= coef_idx_s;
      commit_idx_r   <= commit_idx_s;
      in_ready_r     <= in_ready_s;
      param_in_r     <= param_in_s;
      param_target_r <= param_target_s;
      write_param_r  <= write_param_s;
      hold_r         <= hold_s;
      load_done_r    <= load_done_s;
      csum_err_r     <= csum_err_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign param_in     = param_in_r;
  assign param_target = param_target_r;
  assign write_param  = write_param_r;
  assign hold         = hold_r;
  assign load_done    = load_done_r;
  assign csum_err     = csum_err_r;

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Directed testbench for biquad_coef_loader. A negedge monitor records every
// coefficient write and counts pulses; each test task checks its own results.
module tb_biquad_coef_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        biq_ready;
  logic        biq_start;
  logic [15:0] param_in;
  logic [2:0]  param_target;
  logic        write_param;
  logic        hold;
  logic        load_done;
  logic        csum_err;

  int n_checks;
  int n_fail;
  int cyc;
  int last_acc_cyc;
  int first_wr_cyc;
  int ld_cyc;
  int ld_cnt;
  int ce_cnt;
  int hold_mis;
  int proto_viol;
  logic [2:0]  tq[$];
  logic [15:0] dq[$];

  logic [7:0]  fa [12];
  logic [7:0]  fa_bad [12];
  logic [7:0]  fb [12];
  logic [15:0] ea [5];
  logic [15:0] eb [5];

  biquad_coef_loader #(.data_width(16), .n_coefs(5), .sync_byte(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .biq_ready(biq_ready), .biq_start(biq_start),
    .param_in(param_in), .param_target(param_target), .write_param(write_param),
    .hold(hold), .load_done(load_done), .csum_err(csum_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record writes and pulses away from the active edge.
  always @(negedge clk) begin
    if (write_param === 1'b1) begin
      if (tq.size() == 0) first_wr_cyc = cyc;
      tq.push_back(param_target);
      dq.push_back(param_in);
    end
    if (load_done === 1'b1) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
    if (csum_err === 1'b1) ce_cnt++;
    if (hold !== write_param) hold_mis++;
    if (hold === 1'b1 && biq_start === 1'b1) proto_viol++;
  end

  task automatic clear_mon();
    tq.delete();
    dq.delete();
    ld_cnt = 0;
    ce_cnt = 0;
    first_wr_cyc = -1;
    ld_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      in_data  = b;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (done) begin
      last_acc_cyc = cyc;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted within 200 cycles", b);
    end
  endtask

  // Sends a whole frame; returns on the negedge after the last byte's edge.
  task automatic send_frame(input logic [7:0] f [12], input bit rnd);
    for (int i = 0; i < 12; i++) send_byte(f[i], rnd);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 8'h00; biq_ready = 1'b1; biq_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, param_in, param_target, write_param, hold, load_done, csum_err} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b pin=%h tgt=%0d wr=%b hold=%b ld=%b ce=%b expected all 0",
               in_ready, param_in, param_target, write_param, hold, load_done, csum_err);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_valid_frame();
    clear_mon();
    biq_ready = 1'b1; biq_start = 1'b0;
    send_frame(fa, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (tq.size() != 5) begin
      n_fail++;
      $display("FAIL valid_wr_count: got %0d expected 5", tq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (tq[i] !== 3'(i) || dq[i] !== ea[i]) begin
          n_fail++;
          $display("FAIL valid_wr%0d: got tgt=%0d data=%h expected tgt=%0d data=%h", i, tq[i], dq[i], i, ea[i]);
        end
      end
    end
    n_checks++;
    if (first_wr_cyc != last_acc_cyc + 1 || ld_cyc != last_acc_cyc + 6) begin
      n_fail++;
      $display("FAIL valid_latency: got first_wr=%0d load_done=%0d expected %0d and %0d",
               first_wr_cyc, ld_cyc, last_acc_cyc + 1, last_acc_cyc + 6);
    end
    n_checks++;
    if (ld_cnt != 1 || ce_cnt != 0) begin
      n_fail++;
      $display("FAIL valid_pulses: got load_done=%0d csum_err=%0d expected 1 and 0", ld_cnt, ce_cnt);
    end
  endtask

  task automatic test_bad_csum();
    clear_mon();
    biq_ready = 1'b1; biq_start = 1'b0;
    send_frame(fa_bad, 1'b0);
    n_checks++;
    if (csum_err !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_csum_cycle: got csum_err=%b in_ready=%b expected 1 and 1", csum_err, in_ready);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (ce_cnt != 1 || tq.size() != 0 || ld_cnt != 0) begin
      n_fail++;
      $display("FAIL bad_csum_effects: got csum_err=%0d writes=%0d load_done=%0d expected 1,0,0",
               ce_cnt, tq.size(), ld_cnt);
    end
    clear_mon();
    send_frame(fa, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (tq.size() != 5 || dq[0] !== 16'h4000 || tq[4] !== 3'd4 || ld_cnt != 1) begin
      n_fail++;
      $display("FAIL bad_csum_recover: got writes=%0d load_done=%0d expected 5 and 1", tq.size(), ld_cnt);
    end
  endtask

  task automatic test_hunt_resync(input bit rnd, input string tag);
    clear_mon();
    biq_ready = 1'b1; biq_start = 1'b0;
    send_byte(8'h00, rnd);
    send_byte(8'hFF, rnd);
    send_frame(fb, rnd);
    repeat (10) @(negedge clk);
    n_checks++;
    if (tq.size() != 5) begin
      n_fail++;
      $display("FAIL %s_wr_count: got %0d expected 5", tag, tq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (tq[i] !== 3'(i) || dq[i] !== eb[i]) begin
          n_fail++;
          $display("FAIL %s_wr%0d: got tgt=%0d data=%h expected tgt=%0d data=%h", tag, i, tq[i], dq[i], i, eb[i]);
        end
      end
    end
    n_checks++;
    if (ld_cnt != 1 || ce_cnt != 0) begin
      n_fail++;
      $display("FAIL %s_pulses: got load_done=%0d csum_err=%0d expected 1 and 0", tag, ld_cnt, ce_cnt);
    end
  endtask

  task automatic test_pending_wait();
    int bad;
    int k;
    clear_mon();
    bad = 0;
    biq_ready = 1'b0; biq_start = 1'b0;
    send_frame(fa, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || write_param !== 1'b0 || hold !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pending_wait: got %0d cycles with ready/write/hold active expected 0", bad);
    end
    biq_ready = 1'b1; biq_start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (write_param !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_start_blocks: got write_param=%b in_ready=%b expected 0 and 0", write_param, in_ready);
    end
    biq_start = 1'b0;
    k = cyc;
    repeat (10) @(negedge clk);
    n_checks++;
    if (first_wr_cyc != k + 1 || tq.size() != 5 || ld_cnt != 1) begin
      n_fail++;
      $display("FAIL pending_commit: got first_wr=%0d writes=%0d load_done=%0d expected %0d,5,1",
               first_wr_cyc, tq.size(), ld_cnt, k + 1);
    end
  endtask

  task automatic test_reset_in_commit();
    bit found;
    int n_before;
    clear_mon();
    found = 1'b0;
    biq_ready = 1'b1; biq_start = 1'b0;
    send_frame(fa, 1'b0);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (write_param === 1'b1 && param_target === 3'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_commit_reach: got no third commit cycle expected one within 20 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (write_param !== 1'b0 || hold !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_commit_abort: got write_param=%b hold=%b expected 0 and 0", write_param, hold);
    end
    @(negedge clk);
    reset = 1'b0;
    n_before = tq.size();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_commit_ready: got in_ready=%b expected 1", in_ready);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (ld_cnt != 0 || tq.size() != n_before || n_before != 3) begin
      n_fail++;
      $display("FAIL rst_commit_nowrites: got load_done=%0d writes=%0d/%0d expected 0 and 3/3",
               ld_cnt, n_before, tq.size());
    end
    clear_mon();
    send_frame(fb, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (tq.size() != 5 || dq[2] !== 16'h0001 || ld_cnt != 1) begin
      n_fail++;
      $display("FAIL rst_commit_reload: got writes=%0d load_done=%0d expected 5 and 1", tq.size(), ld_cnt);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; hold_mis = 0; proto_viol = 0;
    last_acc_cyc = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; biq_ready = 1'b0; biq_start = 1'b0;
    fa     = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
    fa_bad = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41};
    // Data 12 34 A5 00 00 01 FF FF 80 00, XOR = 02.
    fb     = '{8'hA5, 8'h12, 8'h34, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h02};
    ea = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    eb = '{16'h1234, 16'hA500, 16'h0001, 16'hFFFF, 16'h8000};
    clear_mon();

    test_reset();
    test_valid_frame();
    test_bad_csum();
    test_hunt_resync(1'b0, "resync");
    test_pending_wait();
    test_reset_in_commit();
    do_reset();
    test_hunt_resync(1'b1, "random_valid");

    n_checks++;
    if (hold_mis != 0) begin
      n_fail++;
      $display("FAIL hold_vs_write: got %0d cycles where hold differed from write_param expected 0", hold_mis);
    end
    n_checks++;
    if (proto_viol != 0) begin
      n_fail++;
      $display("FAIL start_during_hold: got %0d cycles with biq_start while hold expected 0", proto_viol);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/biquad_coef_loader.md
Name: biquad_coef_loader

Overview:
Writer end of the biquad parameter port. It receives coefficient frames as a byte stream from the control path (SPI/UART command decoder), assembles and checksums them, and holds a complete set in shadow registers. It then commits the set atomically to a biquad unit between samples by driving param_in/param_target/write_param. While committing it asserts hold so the sample scheduler cannot start a sample on a half-updated filter.

Parameters:
data_width, 16, coefficient width; must be a multiple of 8.
n_coefs, 5, number of coefficients per frame, in the order b0, b1, b2, a1, a2 (param_target 0..4).
sync_byte, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_data  input  8  control-path byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte on a cycle where in_valid && in_ready
biq_ready  input  1  biquad ready (idle between samples)
biq_start  input  1  start strobe being issued to the biquad this cycle
param_in  output  data_width  coefficient value to the biquad
param_target  output  3  coefficient index to the biquad
write_param  output  1  write strobe to the biquad
hold  output  1  high while a commit is in progress; scheduler must not assert start
load_done  output  1  one-cycle pulse after the last coefficient is written
csum_err  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Frame format:
  - sync_byte.
  - n_coefs*(data_width/8) data bytes; each coefficient is sent MSB byte first.
  - One checksum byte: the XOR of all data bytes (sync byte excluded).
- All outputs are registered. Reset values: in_ready=0, param_in=0, param_target=0, write_param=0, hold=0, load_done=0, csum_err=0.
- Reset also clears the shadow registers, byte counter, commit index and running XOR, and sets state=HUNT. in_ready goes high the cycle after reset deasserts.
- Reset during DATA, CSUM, PENDING or COMMIT abandons the operation immediately. No further write_param pulses are issued after reset.
- HUNT: in_ready=1. An accepted byte equal to sync_byte clears the XOR and byte counter and moves to DATA. Any other accepted byte is dropped silently.
- DATA: in_ready=1. Each accepted byte shifts into shadow coefficient (counter / bytes_per_coef) and is XORed into the running checksum. After the last data byte, move to CSUM. A sync_byte value inside DATA is data, not a resync.
- CSUM: in_ready=1. On the accepted byte:
  - Match: go to PENDING and drop in_ready.
  - Mismatch: pulse csum_err for one cycle, discard the shadow set, return to HUNT. Live coefficients are untouched.
- PENDING: in_ready=0 (backpressure; no double buffering). On an edge where biq_ready=1 and biq_start=0 are sampled:
  - write_param<=1, param_target<=0, param_in<=shadow[0], hold<=1, state<=COMMIT.
  - If the condition does not hold, wait indefinitely; there is no timeout.
- COMMIT: on each edge, write the next index, so write_param is high for exactly n_coefs consecutive cycles with param_target 0,1,..,n_coefs-1.
  - hold is high for exactly those cycles.
  - On the edge after the last write: write_param<=0, hold<=0, load_done<=1 for one cycle, state<=HUNT, in_ready<=1.
  - biq_ready and biq_start are ignored during COMMIT. Asserting start while hold=1 is a scheduler protocol violation and is flagged by an assertion in the bench.
- Latency: with biq_ready=1 and biq_start=0, the checksum byte accepted at edge N gives PENDING at N+1 and the first write_param visible in cycle N+2. load_done is visible in cycle N+7.
- param_in holds its last written value and param_target holds its last index when write_param=0.

Test Plan:
- Reset, then frame A5 40 00 00 00 00 00 00 00 00 00 40 with biq_ready=1 -> write_param high 5 cycles: target 0 data 16'h4000, then targets 1..4 data 0. hold high the same 5 cycles; load_done pulses once.
- Same frame with checksum 41 -> csum_err pulses once; no write_param; in_ready back to 1 next cycle; the next valid frame loads normally.
- Bytes 00 FF A5 followed by a valid frame -> 00 and FF dropped; frame loads correctly. Data byte A5 inside a frame is stored as data.
- Valid frame with biq_ready=0 for 20 cycles, then 1 with biq_start=1 on that cycle, then 0 -> commit begins only on the first cycle with biq_ready=1 and biq_start=0; in_ready=0 throughout the wait.
- Reset asserted on the third cycle of COMMIT -> write_param=0 and hold=0 the next cycle; no load_done; state HUNT.
- in_valid toggled randomly at 50% across a valid frame -> identical writes to the uninterrupted case; no bytes lost or duplicated.
